// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback
// sources, with a registered write command and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int MEM_W   = 16,
  parameter int SEL_W   = 3,
  parameter int NUM_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  input  logic [NUM_REQ*MEM_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     sb_set,
  input  logic [SEL_W-1:0]         sb_set_sel,
  input  logic                     flush,
  output logic                     rf_wr,
  output logic [SEL_W-1:0]         rf_sel,
  output logic [MEM_W-1:0]         rf_data,
  output logic [(2**SEL_W)-1:0]    pending
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 2**SEL_W;

  logic [PTR_W-1:0] r_rr_ptr;
  logic             r_wr;
  logic [SEL_W-1:0] r_sel;
  logic [MEM_W-1:0] r_data;
  logic [NREG-1:0]  r_pending;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W:0]     w_cand;
  logic [PTR_W:0]     w_nxt;
  logic [PTR_W-1:0]   w_nxt_ptr;
  logic               w_found;
  logic               w_xfer;
  logic [SEL_W-1:0]   w_gnt_sel;
  logic [MEM_W-1:0]   w_gnt_data;
  logic [NREG-1:0]    w_clr_mask;
  logic [NREG-1:0]    w_set_mask;
  logic [NREG-1:0]    w_pend_nxt;

  // Scan from the RR pointer upward, wrapping at NUM_REQ
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[w_cand[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PTR_W-1:0];
      end
    end
    if (w_found && !rst) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_gnt_sel  = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_sel  = req_sel[i*SEL_W +: SEL_W];
        w_gnt_data = req_data[i*MEM_W +: MEM_W];
      end
    end
  end

  always_comb begin
    w_nxt     = {1'b0, w_gnt_idx} + (PTR_W+1)'(1);
    w_nxt_ptr = w_nxt[PTR_W-1:0];
    if (w_nxt >= (PTR_W+1)'(NUM_REQ)) begin
      w_nxt_ptr = '0;
    end
  end

  assign w_xfer = |w_grant;

  // A newer producer issued on the same edge keeps its bit set
  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (w_xfer) begin
      w_clr_mask = NREG'(1) << w_gnt_sel;
    end
    if (sb_set) begin
      w_set_mask = NREG'(1) << sb_set_sel;
    end
    w_pend_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_wr      <= 1'b0;
      r_sel     <= '0;
      r_data    <= '0;
      r_pending <= '0;
    end else begin
      r_wr <= w_xfer;
      if (w_xfer) begin
        r_sel  <= w_gnt_sel;
        r_data <= w_gnt_data;
      end
      if (flush) begin
        r_pending <= '0;
        r_rr_ptr  <= '0;
      end else begin
        r_pending <= w_pend_nxt;
        if (w_xfer) begin
          r_rr_ptr <= w_nxt_ptr;
        end
      end
    end
  end

  assign req_ready = w_grant;
  assign rf_wr     = r_wr;
  assign rf_sel    = r_sel;
  assign rf_data   = r_data;
  assign pending   = r_pending;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ writeback sources: ALU, load unit, and spare.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives a registered write command (wr/sel/data) to the register file.
- Keeps a pending-write scoreboard that the issue logic uses to stall on read-after-write hazards.

Parameters:
- MEM_W, 16, register data width.
- SEL_W, 3, register index width; the register file holds 2**SEL_W entries.
- NUM_REQ, 3, number of writeback requesters, 2..8.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_sel  in  NUM_REQ*SEL_W  destination index; requester i uses bits [i*SEL_W +: SEL_W].
- req_data  in  NUM_REQ*MEM_W  write data, packed the same way as req_sel.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- sb_set  in  1  issue stage marks a destination register as pending.
- sb_set_sel  in  SEL_W  register index marked by sb_set.
- flush  in  1  synchronous clear of the scoreboard and the RR pointer.
- rf_wr  out  1  register-file write strobe, registered.
- rf_sel  out  SEL_W  register-file index, registered.
- rf_data  out  MEM_W  register-file write data, registered.
- pending  out  2**SEL_W  scoreboard; bit k=1 means a write to register k is outstanding.

Behaviour:
- Reset (async, any time): rf_wr=0, rf_sel=0, rf_data=0, pending=0, rr_ptr=0.
  - Any write captured but not yet presented is dropped.
  - While rst is high, req_ready=0.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, ascending with wrap at NUM_REQ.
  - The first one with req_valid=1 gets req_ready=1; all others get 0.
  - No valid requester: req_ready=0.
  - At most one grant per cycle.
- Transfer: occurs for requester i when req_valid[i] and req_ready[i] are both 1 at a rising edge.
  - Requester holds valid/sel/data stable until ready is seen.
  - Dropping valid without a transfer is legal; nothing is written.
- Output timing:
  - On a transfer edge: rf_wr<=1, rf_sel<=req_sel[i], rf_data<=req_data[i].
  - Edge with no transfer: rf_wr<=0; rf_sel and rf_data hold their previous values.
  - Latency is 1 cycle from the transfer edge to the write strobe.
  - Throughput is 1 write per cycle; back-to-back grants are allowed.
- RR pointer:
  - On a transfer by i: rr_ptr<=(i+1) mod NUM_REQ.
  - No transfer: rr_ptr unchanged.
  - A single continuously valid requester is granted every cycle.
  - With all requesters valid, grants rotate 0,1,2,0,... for NUM_REQ=3.
- Scoreboard:
  - sb_set sets pending[sb_set_sel] at the edge.
  - A transfer clears pending[req_sel[i]] at the same edge it is captured.
  - Set and clear of the same index on the same edge: set wins, bit stays 1 (newer producer issued).
  - Set and clear of different indices on the same edge: both take effect.
  - A transfer to a non-pending register is legal and clears nothing.
- Flush (synchronous): pending<=0 and rr_ptr<=0.
  - Takes priority over sb_set that cycle.
  - A transfer in the same cycle still produces its rf_wr.
  - req_ready is unaffected by flush.
- Duplicate targets: two requesters targeting the same register are serialised in grant order; the last grant wins in the register file.

Test Plan:
- Reset mid-transfer: assert rst asynchronously between edges while rf_wr=1 -> rf_wr, rf_sel, rf_data and pending read 0 immediately; req_ready=0 while rst is high.
- Single requester: req_valid=3'b010, sel=5, data=16'hBEEF -> req_ready=3'b010 same cycle; next cycle rf_wr=1, rf_sel=5, rf_data=16'hBEEF; rr_ptr=2.
- Fairness: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; rf_wr=1 on six consecutive cycles with matching sel/data.
- Scoreboard: sb_set sel=3 -> pending=8'h08; later requester 0 writes sel=3 -> pending=8'h00 after the transfer edge, and rf_wr appears the following cycle.
- Simultaneous set/clear: sb_set sel=4 on the same edge requester 1 transfers to sel=4 with pending[4]=1 -> pending[4] stays 1; a second write to 4 then clears it.
- Flush: pending=8'h3C, rr_ptr=2, flush with sb_set sel=1 -> pending=8'h00, rr_ptr=0; with all requesters valid, the next grant goes to requester 0.
